// File: rtl/sm2_pkg.sv
// Shared SM2 definitions: curve constants, datapath width and the
// multiplier-arbiter state encoding.
package sm2_pkg;

  localparam int W = 256;

  localparam logic [255:0] P = 256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
  localparam logic [255:0] A = 256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFC;
  localparam logic [255:0] B = 256'h28E9FA9E_9D9F5E34_4D5A9E4B_CF6509A7_F39789F5_15AB8F92_DDBCBD41_4D940E93;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first set request strictly after `last`,
// wrapping modulo N_REQ, so `last` itself has the lowest priority.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [IW-1:0]    grant_idx,
  output logic             any
);

  // Walk from farthest to nearest so the nearest set bit is written last.
  always_comb begin
    int idx;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % N_REQ;
      if (req[idx]) begin
        grant_idx = IW'(idx);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_mul_arbiter.sv
// Round-robin, non-preemptive sharing of one SM2 modular multiplier among
// N_REQ sequencers; operands latched at grant, product returned with an ack.
module mod_mul_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = sm2_pkg::W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] op_a,
  input  logic [N_REQ*W-1:0] op_b,
  output logic [N_REQ-1:0]   ack,
  output logic [W-1:0]       result,
  output logic               busy,
  output logic               mul_rst_n,
  output logic [W-1:0]       mul_a,
  output logic [W-1:0]       mul_b,
  input  logic [W-1:0]       mul_ab,
  input  logic               mul_done
);
  import sm2_pkg::*;

  localparam int            IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic [IW-1:0] g;
  logic [IW-1:0] last;
  logic [IW-1:0] pick_idx;
  logic          pick_any;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .req       (req),
    .last      (last),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (mul_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant stage: operands are only looked at in IDLE, result only in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      g      <= '0;
      last   <= LAST_RST;
      mul_a  <= '0;
      mul_b  <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_any) begin
        g     <= pick_idx;
        last  <= pick_idx;
        mul_a <= op_a[int'(pick_idx)*W +: W];
        mul_b <= op_b[int'(pick_idx)*W +: W];
      end
      if (state == RUN && mul_done) begin
        result <= mul_ab;
      end
    end
  end

  // Multiplier runs only in RUN, so async reset aborts it at once.
  always_comb begin
    ack = '0;
    if (state == DONE) ack[g] = 1'b1;
    busy      = (state != IDLE);
    mul_rst_n = (state == RUN);
  end

endmodule

// File: tb/tb_mod_mul_arbiter.sv
// Scoreboard bench for mod_mul_arbiter with a mock multiplier whose done
// rises L+1 cycles after mul_rst_n goes high.
module tb_mod_mul_arbiter;

  localparam int N = 4;
  localparam int W = 256;
  localparam int L = 10;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [N*W-1:0]   op_a;
  logic [N*W-1:0]   op_b;
  logic [N-1:0]     ack;
  logic [W-1:0]     result;
  logic             busy;
  logic             mul_rst_n;
  logic [W-1:0]     mul_a;
  logic [W-1:0]     mul_b;
  logic [W-1:0]     mul_ab;
  logic             mul_done;

  logic [7:0]       cnt;
  logic             mock_done;
  logic             stale_done;
  logic [W-1:0]     prod;

  typedef struct packed {
    logic [N-1:0] ack;
    logic [W-1:0] res;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_pass;

  mod_mul_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .ack       (ack),
    .result    (result),
    .busy      (busy),
    .mul_rst_n (mul_rst_n),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_ab    (mul_ab),
    .mul_done  (mul_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mock multiplier: product only visible once its own done is up.
  always @(posedge clk) begin
    if (!mul_rst_n) begin
      cnt       <= '0;
      mock_done <= 1'b0;
    end else begin
      cnt <= cnt + 8'd1;
      if (cnt == 8'(L)) mock_done <= 1'b1;
    end
  end
  assign prod     = mul_a * mul_b;
  assign mul_ab   = mock_done ? prod : W'(16'hDEAD);
  assign mul_done = mock_done | stale_done;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: every ack must match the head of the scoreboard queue.
  always @(negedge clk) begin
    if (rst_n && ack != '0) begin
      if (exp_q.size() == 0) begin
        chk("ack_unexpected", W'(ack), '0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ack_onehot", W'(ack), W'(e.ack));
        chk("result", result, e.res);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    op_a[i*W +: W] = a;
    op_b[i*W +: W] = b;
  endtask

  task automatic push(input int i, input logic [W-1:0] r);
    exp_t e;
    e.ack = N'(1) << i;
    e.res = r;
    exp_q.push_back(e);
  endtask

  task automatic wait_ack(input string name, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (ack == '0 && n < 200);
    chk({name, "_ack_seen"}, W'(ack != '0), W'(1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int   n;
    logic [W-1:0] big;
    n_checks   = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    req        = '0;
    op_a       = '0;
    op_b       = '0;
    stale_done = 1'b0;
    tick();
    tick();

    chk("rst_ack", W'(ack), '0);
    chk("rst_result", result, '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_mul_rst_n", W'(mul_rst_n), '0);
    chk("rst_mul_a", mul_a, '0);
    chk("rst_mul_b", mul_b, '0);
    rst_n = 1'b1;
    tick();

    // Single request: 3*5, ack 14 cycles after the request cycle.
    set_op(0, 3, 5);
    req = 4'b0001;
    push(0, 15);
    tick();
    req = '0;
    chk("single_mul_a", mul_a, 3);
    chk("single_mul_b", mul_b, 5);
    wait_ack("single", n);
    chk("single_latency", W'(n + 1), W'(14));
    chk("single_busy_in_ack", W'(busy), W'(1));
    tick();
    chk("single_busy_after", W'(busy), '0);

    // All four held high from reset: order 0,1,2,3,0.
    do_reset();
    big = '1;
    set_op(0, 10, 3);
    set_op(1, 20, 4);
    set_op(2, 30, 5);
    set_op(3, big, 2);
    push(0, 30);
    push(1, 80);
    push(2, 150);
    push(3, {{(W-1){1'b1}}, 1'b0});
    push(0, 30);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack("all4", n);
    end
    req = '0;
    tick();

    // Fairness: make last=2, then 0101 gives 0 then 2.
    do_reset();
    set_op(2, 7, 7);
    push(2, 49);
    req = 4'b0100;
    tick();
    req = '0;
    wait_ack("fair_setup", n);
    tick();
    set_op(0, 6, 6);
    set_op(2, 9, 9);
    push(0, 36);
    push(2, 81);
    req = 4'b0101;
    wait_ack("fair_first", n);
    wait_ack("fair_second", n);
    req = '0;
    tick();

    // Drop req[1] during RUN and scramble its operands; 3 waits behind it.
    big = '0;
    big[128] = 1'b1;
    set_op(1, 11, 13);
    set_op(3, big + 5, big);
    push(1, 143);
    push(3, W'(5) << 128);
    req = 4'b0010;
    tick();
    set_op(1, 999, 999);
    tick();
    chk("drop_in_run", W'(mul_rst_n), W'(1));
    req = 4'b1000;
    wait_ack("drop_ack1", n);
    wait_ack("drop_ack3", n);
    req = '0;
    tick();

    // Stale done high through LOAD must not be captured.
    stale_done = 1'b1;
    set_op(0, 7, 9);
    push(0, 63);
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    stale_done = 1'b0;
    chk("stale_in_run", W'(mul_rst_n), W'(1));
    wait_ack("stale", n);
    chk("stale_latency", W'(n + 2), W'(14));
    tick();

    // Async reset in RUN: no ack, then pointer restarts at requester 0.
    set_op(1, 4, 4);
    req = 4'b0010;
    tick();
    req = '0;
    tick();
    chk("abort_in_run", W'(mul_rst_n), W'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_mul_rst_n_now", W'(mul_rst_n), '0);
    chk("abort_busy_now", W'(busy), '0);
    tick();
    chk("abort_ack", W'(ack), '0);
    chk("abort_result", result, '0);
    chk("abort_mul_a", mul_a, '0);
    chk("abort_mul_rst_n", W'(mul_rst_n), '0);
    rst_n = 1'b1;
    set_op(3, 6, 7);
    push(3, 42);
    req = 4'b1000;
    tick();
    req = '0;
    chk("after_abort_mul_a", mul_a, 6);
    wait_ack("after_abort", n);
    chk("after_abort_latency", W'(n + 1), W'(14));
    tick();
    tick();

    chk("queue_drained", W'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
